// File: rtl/freq_spectrum_capture.sv
// Captures the first NUM_BINS power bins of each FFT output frame into a
// ping-pong spectrum memory, tracking the peak bin, with a registered display read port.
module freq_spectrum_capture #(
    parameter int NUM_BINS = 512,
    parameter int ADDR_W   = 9
) (
    input  logic              ckFreq,
    input  logic              aresetn,
    input  logic              enaCapture,
    input  logic              freeze,
    input  logic              flgFreqSampleValid,
    input  logic [9:0]        addrFreq,
    input  logic [7:0]        byteFreqSample,
    input  logic [ADDR_W-1:0] addrRead,
    output logic [7:0]        byteRead,
    output logic [ADDR_W-1:0] peakBin,
    output logic [7:0]        peakVal,
    output logic              flgFrameReady,
    output logic              flgCapturing,
    output logic [7:0]        cntSyncErr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_CAPTURE,
        ST_SWAP
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NUM_BINS - 1);

    state_t            state, state_nxt;
    logic              wr_bank;
    logic [ADDR_W-1:0] expected;
    logic [ADDR_W-1:0] run_bin;
    logic [7:0]        run_val;
    logic [7:0]        mem [0:2*NUM_BINS-1];

    logic              smp;
    logic [ADDR_W-1:0] bin;
    logic              wr_en, start, adv, abort, swap;

    // Mirror-half bins never count as samples, so they cannot start or break a frame.
    assign smp = flgFreqSampleValid && ({1'b0, addrFreq} < 11'(NUM_BINS));
    assign bin = addrFreq[ADDR_W-1:0];

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        start     = 1'b0;
        adv       = 1'b0;
        abort     = 1'b0;
        swap      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enaCapture) state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (!enaCapture) begin
                    state_nxt = ST_IDLE;
                end else if (smp && bin == '0) begin
                    wr_en     = 1'b1;
                    start     = 1'b1;
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!enaCapture) begin
                    state_nxt = ST_IDLE;
                end else if (smp) begin
                    if (bin == expected) begin
                        wr_en = 1'b1;
                        adv   = 1'b1;
                        if (expected == LAST_BIN) state_nxt = ST_SWAP;
                    end else begin
                        abort     = 1'b1;
                        state_nxt = ST_SYNC;
                    end
                end
            end
            ST_SWAP: begin
                swap      = !freeze;
                state_nxt = enaCapture ? ST_SYNC : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign flgFrameReady = swap;

    always_ff @(posedge ckFreq or negedge aresetn) begin
        if (!aresetn) begin
            state        <= ST_IDLE;
            flgCapturing <= 1'b0;
            wr_bank      <= 1'b0;
            expected     <= '0;
            run_bin      <= '0;
            run_val      <= '0;
            peakBin      <= '0;
            peakVal      <= '0;
            cntSyncErr   <= '0;
        end else begin
            state        <= state_nxt;
            flgCapturing <= (state_nxt == ST_CAPTURE);
            if (start) begin
                expected <= ADDR_W'(1);
                run_bin  <= '0;
                run_val  <= byteFreqSample;
            end else if (adv) begin
                expected <= expected + 1'b1;
                // Strictly greater: the lowest bin keeps the peak on ties.
                if (byteFreqSample > run_val) begin
                    run_bin <= bin;
                    run_val <= byteFreqSample;
                end
            end
            if (swap) begin
                wr_bank <= ~wr_bank;
                peakBin <= run_bin;
                peakVal <= run_val;
            end
            if (abort && cntSyncErr != 8'hFF) cntSyncErr <= cntSyncErr + 8'd1;
        end
    end

    always_ff @(posedge ckFreq) begin
        if (wr_en) mem[{wr_bank, bin}] <= byteFreqSample;
    end

    // The display bank is always the one not being written.
    always_ff @(posedge ckFreq or negedge aresetn) begin
        if (!aresetn) byteRead <= '0;
        else          byteRead <= mem[{~wr_bank, addrRead}];
    end

endmodule

// File: doc/freq_spectrum_capture.md
Name: freq_spectrum_capture

Overview:
Consumer of the FFT block's frequency-sample output stream (flgFreqSampleValid / addrFreq / byteFreqSample). It aligns to the start of each FFT output frame and captures the first NUM_BINS power bins into a double-buffered spectrum memory. It tracks the peak bin per frame and exposes a stable, completed frame through a registered read port for the display/VGA path. Runs entirely in the FFT clock domain.

Parameters:
NUM_BINS, 512, bins captured per frame, starting at addrFreq = 0; must be a power of 2 and no greater than 1024.
ADDR_W, 9, log2(NUM_BINS); width of the read address and peak-bin outputs.

Ports:
ckFreq  input  1  FFT/frequency-domain clock; all logic on its rising edge.
aresetn  input  1  asynchronous active-low reset.
enaCapture  input  1  level; 1 = capture frames, 0 = idle.
freeze  input  1  level; 1 = hold the displayed frame, so completed frames are discarded.
flgFreqSampleValid  input  1  frequency sample valid strobe.
addrFreq  input  10  bin index of the current sample.
byteFreqSample  input  8  unsigned power magnitude of the current sample.
addrRead  input  ADDR_W  display read address.
byteRead  output  8  registered read data from the display bank.
peakBin  output  ADDR_W  bin index of the maximum in the displayed frame.
peakVal  output  8  magnitude at peakBin.
flgFrameReady  output  1  one-cycle pulse when a new frame becomes the display frame.
flgCapturing  output  1  high while in stCapture.
cntSyncErr  output  8  count of aborted frames; saturates at 255.

Behaviour:
- Reset (async, aresetn = 0): state = stIdle, both banks' pointers at 0 (wrBank = 0, rdBank = 1). byteRead, peakBin, peakVal, flgFrameReady, flgCapturing and cntSyncErr are all 0. Memory contents are not reset.
- Memory: two banks of NUM_BINS x 8, with one write port and one read port. A write goes to wrBank and a read comes from rdBank. The banks never alias, so there are no read/write collisions.
- Read latency: 1 cycle. byteRead(t+1) = mem[rdBank][addrRead(t)]. This holds in every state.
- States:
  - stIdle: go to stSync when enaCapture = 1.
  - stSync: wait for valid with addrFreq = 0. Then write bin 0, set the running peak to (0, byte), set expected = 1, and go to stCapture. Valid samples at any other address are ignored without counting an error.
  - stCapture: on valid with addrFreq = expected:
    - write the sample;
    - if byte > running peak value (strictly greater, so the lowest bin wins ties), update the peak;
    - increment expected.
    - When the write at addrFreq = NUM_BINS-1 completes, go to stSwap.
    - Valid with addrFreq != expected: abort the frame, increment cntSyncErr (saturating), go to stSync. The offending sample is dropped, even if its address is 0.
    - Cycles with valid = 0 are tolerated with no timeout.
  - stSwap (exactly 1 cycle):
    - If freeze = 0: swap wrBank and rdBank, load peakBin/peakVal from the running peak, and pulse flgFrameReady for that cycle.
    - If freeze = 1: no swap, no pulse, peak outputs unchanged. The next frame overwrites the same write bank.
    - Next state is stSync if enaCapture = 1, otherwise stIdle.
- Bins with addrFreq >= NUM_BINS (the upper mirror half) are ignored in all states.
- enaCapture falling in stSync or stCapture: go to stIdle on the next edge. The partial frame is discarded, with no error count and no swap.
- flgCapturing = 1 exactly when state = stCapture (registered along with the state).
- Toggling freeze mid-frame has no effect until stSwap. Its value is sampled only in stSwap.
- The peak is computed only over captured bins. peakBin/peakVal change only on a swap.

Test Plan:
- Reset, then enaCapture = 1, one frame with byte = addr[7:0] for addr 0..1023, back-to-back valid -> flgFrameReady pulses once, 1 cycle after the addr-511 sample. Reading addr 37 returns 37 one cycle later. peakBin = 255, peakVal = 255 (the first bin holding 255 wins the tie).
- Frame where bins 100 and 300 both = 0xF0 and all others = 0x10 -> peakBin = 100, peakVal = 0xF0. With valid gapped every 3rd cycle, the result is the same and there is no error.
- Mid-frame skip: addr 0..199, then 201 -> cntSyncErr = 1, no flgFrameReady, previous display frame unchanged. The next clean frame completes normally.
- freeze = 1 during a full frame with bin 5 = 0xAA (displayed bin 5 = 0x11) -> no pulse, read addr 5 still = 0x11. freeze = 0 on the next frame with bin 5 = 0xBB -> pulse, read = 0xBB.
- enaCapture dropped at addr 300 -> flgCapturing = 0 the next cycle, state stIdle, no pulse, cntSyncErr unchanged. Re-enable starts at the next addr-0 sample.
- aresetn asserted mid-capture -> all outputs 0 immediately (async). 256+ sync errors -> cntSyncErr holds at 255.
